// File: rtl/scene_frame_sequencer_pkg.sv
// scene_frame_sequencer_pkg: shared types for the scene frame sequencer.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: WORD_W, coord_t (signed Q3.12), vertex_t {x,y,z,w}, seq_state_e, idx_width().
package scene_frame_sequencer_pkg;

  localparam int WORD_W = 16;

  typedef logic signed [WORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    coord_t z;
    coord_t w;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE,
    RECV_VERT,
    RECV_LINE,
    DRAW,
    DONE
  } seq_state_e;

  // Index width for an n-entry store; never narrower than one bit so that a
  // single-entry store still has a legal index vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scene_frame_sequencer_if.sv
// scene_word_if / scene_line_if: SPI word stream in, line draw requests out.
// Latency: n/a (wiring only).
// Backpressure: word stream has none; line requests use io_line_valid/io_line_ready.
// scene_word_if: io_spi_cs (active low), io_word_valid (1-cycle pulse), io_word.
// scene_line_if: io_line_valid, io_line_ready, endpoint 0/1 coordinates.
interface scene_word_if;
  import scene_frame_sequencer_pkg::*;

  logic              io_spi_cs;
  logic              io_word_valid;
  logic [WORD_W-1:0] io_word;

  modport master (output io_spi_cs, output io_word_valid, output io_word);
  modport slave  (input  io_spi_cs, input  io_word_valid, input  io_word);
endinterface

interface scene_line_if;
  import scene_frame_sequencer_pkg::*;

  logic   io_line_valid;
  logic   io_line_ready;
  coord_t io_x0, io_y0, io_z0, io_w0;
  coord_t io_x1, io_y1, io_z1, io_w1;

  modport master (
    output io_line_valid, input io_line_ready,
    output io_x0, output io_y0, output io_z0, output io_w0,
    output io_x1, output io_y1, output io_z1, output io_w1
  );
  modport slave (
    input io_line_valid, output io_line_ready,
    input io_x0, input io_y0, input io_z0, input io_w0,
    input io_x1, input io_y1, input io_z1, input io_w1
  );
endinterface

// File: rtl/scene_frame_sequencer_vertex_store.sv
// vertex_store: NUM_VERTS x vertex_t register file, one component write port, two reads.
// Latency: write lands on the clock edge it is presented; reads are combinational.
// Backpressure: none; every write is accepted.
// Ports: clock, wr_en/wr_vidx/wr_comp/wr_dat, rd_a_idx->rd_a_dat, rd_b_idx->rd_b_dat.
module vertex_store
  import scene_frame_sequencer_pkg::*;
#(
  parameter int NUM_VERTS = 4,
  parameter int IDX_W     = idx_width(NUM_VERTS)
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_vidx,
  input  logic [1:0]       wr_comp,
  input  coord_t           wr_dat,
  input  logic [IDX_W-1:0] rd_a_idx,
  output vertex_t          rd_a_dat,
  input  logic [IDX_W-1:0] rd_b_idx,
  output vertex_t          rd_b_dat
);

  vertex_t vert_q [NUM_VERTS];
  vertex_t vert_d [NUM_VERTS];

  always_comb begin
    vert_d = vert_q;
    if (wr_en) begin
      case (wr_comp)
        2'd0: vert_d[wr_vidx].x = wr_dat;
        2'd1: vert_d[wr_vidx].y = wr_dat;
        2'd2: vert_d[wr_vidx].z = wr_dat;
        2'd3: vert_d[wr_vidx].w = wr_dat;
      endcase
    end
  end

  // Contents are fully rewritten by every frame before they are read, so the
  // store carries no reset.
  always_ff @(posedge clock) begin
    vert_q <= vert_d;
  end

  assign rd_a_dat = vert_q[rd_a_idx];
  assign rd_b_dat = vert_q[rd_b_idx];

endmodule

// File: rtl/scene_frame_sequencer.sv
// scene_frame_sequencer: collects one SPI scene frame (vertices, then index pairs) and replays it as line requests.
// Latency: first request is valid the cycle after the last index word; one request per cycle while ready is high.
// Backpressure: payload held while io_line_valid && !io_line_ready; SPI words are never stalled (late words flag io_err).
// Ports: clock, io_aresetn (async, active low), word_if (slave: cs/word stream), line_if (master: requests),
//        io_busy (not IDLE), io_frame_done (1-cycle pulse), io_err (sticky until next frame start).
module scene_frame_sequencer
  import scene_frame_sequencer_pkg::*;
#(
  parameter int NUM_VERTS = 4,
  parameter int NUM_LINES = 4
) (
  input  logic         clock,
  input  logic         io_aresetn,
  scene_word_if.slave  word_if,
  scene_line_if.master line_if,
  output logic         io_busy,
  output logic         io_frame_done,
  output logic         io_err
);

  localparam int IDX_W  = idx_width(NUM_VERTS);
  localparam int LIDX_W = idx_width(NUM_LINES);
  localparam logic [IDX_W-1:0]  LAST_VERT = IDX_W'(NUM_VERTS - 1);
  localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(NUM_LINES - 1);

  // Stored index = {bad, low index bits}. "bad" folds the range check and the
  // nonzero-upper-bits check into one compare on the full received word.
  function automatic logic [IDX_W:0] enc_idx(input logic [WORD_W-1:0] w);
    return {(32'(w) >= 32'(NUM_VERTS)), w[IDX_W-1:0]};
  endfunction

  seq_state_e        state_q, state_d;
  logic [1:0]        comp_q, comp_d;
  logic [IDX_W-1:0]  vidx_q, vidx_d;
  logic [LIDX_W-1:0] lidx_q, lidx_d;
  logic              half_q, half_d;
  logic              cs_q, cs_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  vertex_t           p0_q, p0_d, p1_q, p1_d;

  logic [IDX_W:0]    line_a_q [NUM_LINES];
  logic [IDX_W:0]    line_a_d [NUM_LINES];
  logic [IDX_W:0]    line_b_q [NUM_LINES];
  logic [IDX_W:0]    line_b_d [NUM_LINES];

  logic              cs_fall, cs_rise, vs_we;
  logic [LIDX_W-1:0] load_idx;
  logic [IDX_W:0]    ent_a, ent_b;
  vertex_t           rd_a, rd_b;

  assign cs_d    = word_if.io_spi_cs;
  assign cs_fall = cs_q & ~word_if.io_spi_cs;
  assign cs_rise = ~cs_q & word_if.io_spi_cs;
  assign vs_we   = (state_q == RECV_VERT) && word_if.io_word_valid;

  vertex_store #(
    .NUM_VERTS (NUM_VERTS),
    .IDX_W     (IDX_W)
  ) u_vertex_store (
    .clock    (clock),
    .wr_en    (vs_we),
    .wr_vidx  (vidx_q),
    .wr_comp  (comp_q),
    .wr_dat   (coord_t'(word_if.io_word)),
    .rd_a_idx (ent_a[IDX_W-1:0]),
    .rd_a_dat (rd_a),
    .rd_b_idx (ent_b[IDX_W-1:0]),
    .rd_b_dat (rd_b)
  );

  // Line index store write port.
  always_comb begin
    line_a_d = line_a_q;
    line_b_d = line_b_q;
    if (state_q == RECV_LINE && word_if.io_word_valid) begin
      if (!half_q) line_a_d[lidx_q] = enc_idx(word_if.io_word);
      else         line_b_d[lidx_q] = enc_idx(word_if.io_word);
    end
  end

  // Line to be loaded into the output registers on this edge. Entering DRAW
  // loads line 0; it is read from the _d side so that the index word being
  // written this very cycle is already visible.
  assign load_idx = (state_q == DRAW) ? (lidx_q + LIDX_W'(1)) : '0;
  assign ent_a    = line_a_d[load_idx];
  assign ent_b    = line_b_d[load_idx];

  always_comb begin
    state_d = state_q;
    comp_d  = comp_q;
    vidx_d  = vidx_q;
    lidx_d  = lidx_q;
    half_d  = half_q;
    err_d   = err_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    p0_d    = p0_q;
    p1_d    = p1_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = RECV_VERT;
          comp_d  = '0;
          vidx_d  = '0;
          lidx_d  = '0;
          half_d  = 1'b0;
          err_d   = 1'b0;
        end
      end

      RECV_VERT: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (word_if.io_word_valid) begin
          comp_d = comp_q + 2'd1;
          if (comp_q == 2'd3) begin
            if (vidx_q == LAST_VERT) begin
              vidx_d  = '0;
              state_d = RECV_LINE;
            end else begin
              vidx_d = vidx_q + IDX_W'(1);
            end
          end
        end
      end

      RECV_LINE: begin
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (word_if.io_word_valid) begin
          half_d = ~half_q;
          if (half_q) begin
            if (lidx_q == LAST_LINE) begin
              lidx_d  = '0;
              state_d = DRAW;
              valid_d = ~(ent_a[IDX_W] | ent_b[IDX_W]);
              err_d   = err_q | ent_a[IDX_W] | ent_b[IDX_W];
              if (!(ent_a[IDX_W] | ent_b[IDX_W])) begin
                p0_d = rd_a;
                p1_d = rd_b;
              end
            end else begin
              lidx_d = lidx_q + LIDX_W'(1);
            end
          end
        end
      end

      DRAW: begin
        if (word_if.io_word_valid) err_d = 1'b1;
        // A slot ends on acceptance, or after its single cycle if skipped.
        if (!valid_q || line_if.io_line_ready) begin
          if (lidx_q == LAST_LINE) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            lidx_d  = load_idx;
            valid_d = ~(ent_a[IDX_W] | ent_b[IDX_W]);
            if (ent_a[IDX_W] | ent_b[IDX_W]) begin
              err_d = 1'b1;
            end else begin
              p0_d = rd_a;
              p1_d = rd_b;
            end
          end
        end
      end

      DONE: begin
        if (word_if.io_word_valid) err_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge io_aresetn) begin
    if (!io_aresetn) begin
      state_q <= IDLE;
      comp_q  <= '0;
      vidx_q  <= '0;
      lidx_q  <= '0;
      half_q  <= 1'b0;
      cs_q    <= 1'b1;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      p0_q    <= '0;
      p1_q    <= '0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      vidx_q  <= vidx_d;
      lidx_q  <= lidx_d;
      half_q  <= half_d;
      cs_q    <= cs_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
    end
  end

  // Index pairs are rewritten by every frame before use; no reset needed.
  always_ff @(posedge clock) begin
    line_a_q <= line_a_d;
    line_b_q <= line_b_d;
  end

  assign line_if.io_line_valid = valid_q;
  assign line_if.io_x0 = p0_q.x;
  assign line_if.io_y0 = p0_q.y;
  assign line_if.io_z0 = p0_q.z;
  assign line_if.io_w0 = p0_q.w;
  assign line_if.io_x1 = p1_q.x;
  assign line_if.io_y1 = p1_q.y;
  assign line_if.io_z1 = p1_q.z;
  assign line_if.io_w1 = p1_q.w;

  assign io_busy       = (state_q != IDLE);
  assign io_frame_done = done_q;
  assign io_err        = err_q;

endmodule

// File: tb/tb_scene_frame_sequencer.sv
module tb_scene_frame_sequencer;
  import scene_frame_sequencer_pkg::*;

  localparam int BUDGET = 500;

  typedef struct packed {
    logic [63:0] p0;
    logic [63:0] p1;
  } seg_t;

  logic clock = 1'b0;
  logic io_aresetn;
  logic io_busy, io_frame_done, io_err;

  scene_word_if word_if ();
  scene_line_if line_if ();

  scene_frame_sequencer #(.NUM_VERTS(4), .NUM_LINES(4)) dut (
    .clock         (clock),
    .io_aresetn    (io_aresetn),
    .word_if       (word_if),
    .line_if       (line_if),
    .io_busy       (io_busy),
    .io_frame_done (io_frame_done),
    .io_err        (io_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Frame content driven by the bench (and read by the reference model).
  logic [15:0] mv [4][4];
  logic [15:0] ma [4];
  logic [15:0] mb [4];
  bit          rdy_pat [600];

  // Observations and expectations.
  seg_t acc_q [$];
  seg_t exp_q [$];
  int   valid_cycles, done_cnt, done_at, first_valid_at, stall_changes;
  bit   timed_out;
  bit   exp_err;
  int   exp_done_at, exp_valid_cycles;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic seg_t cur_seg();
    return {line_if.io_x0, line_if.io_y0, line_if.io_z0, line_if.io_w0,
            line_if.io_x1, line_if.io_y1, line_if.io_z1, line_if.io_w1};
  endfunction

  function automatic logic [63:0] vtx(input int i);
    return {mv[i][0], mv[i][1], mv[i][2], mv[i][3]};
  endfunction

  // Reference model: list of drawable lines in order, error if any index is
  // out of range, and slot timing (a good line waits for ready, a bad one
  // costs one cycle) giving the cycle on which frame_done is seen.
  task automatic build_model();
    int t;
    t = 0;
    exp_q.delete();
    exp_err = 1'b0;
    exp_valid_cycles = 0;
    for (int l = 0; l < 4; l++) begin
      if (ma[l] < 16'd4 && mb[l] < 16'd4) begin
        int t0;
        t0 = t;
        exp_q.push_back({vtx(int'(ma[l])), vtx(int'(mb[l]))});
        while (t < BUDGET && !rdy_pat[t]) t++;
        t++;
        exp_valid_cycles += t - t0;
      end else begin
        exp_err = 1'b1;
        t++;
      end
    end
    exp_done_at = t;
  endtask

  task automatic set_square();
    logic [15:0] sq [4][4];
    sq[0] = '{16'hF800, 16'hF800, 16'h0000, 16'h1000};
    sq[1] = '{16'h0800, 16'hF800, 16'h0000, 16'h1000};
    sq[2] = '{16'h0800, 16'h0800, 16'h0000, 16'h1000};
    sq[3] = '{16'hF800, 16'h0800, 16'h0000, 16'h1000};
    for (int v = 0; v < 4; v++)
      for (int c = 0; c < 4; c++) mv[v][c] = sq[v][c];
    for (int l = 0; l < 4; l++) begin
      ma[l] = 16'(l);
      mb[l] = 16'((l + 1) % 4);
    end
  endtask

  // 0: always ready, 1: one on / two off, 2: random, 3: stalled for 3 cycles.
  task automatic fill_ready(input int mode);
    for (int i = 0; i < 600; i++) begin
      case (mode)
        0:       rdy_pat[i] = 1'b1;
        1:       rdy_pat[i] = (i % 3 == 0);
        2:       rdy_pat[i] = ($urandom_range(0, 1) == 1);
        default: rdy_pat[i] = (i >= 3);
      endcase
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    word_if.io_word_valid = 1'b1;
    word_if.io_word       = w;
    tick();
    word_if.io_word_valid = 1'b0;
  endtask

  // Sends the whole frame; returns on the first DRAW cycle with cs raised
  // (a cs edge during DRAW must be ignored).
  task automatic drive_frame(input bit gaps);
    line_if.io_line_ready = 1'b0;
    word_if.io_spi_cs = 1'b0;
    tick();
    for (int v = 0; v < 4; v++)
      for (int c = 0; c < 4; c++) send_word(mv[v][c], gaps);
    for (int l = 0; l < 4; l++) begin
      send_word(ma[l], gaps);
      send_word(mb[l], gaps);
    end
    word_if.io_spi_cs = 1'b1;
  endtask

  // Records the DRAW phase: accepted payloads, valid count, done pulses,
  // payload changes while stalled. Optionally injects one stray word.
  task automatic collect(input int inject_at);
    seg_t prev;
    bit   prev_stall;
    bit   rdy;
    prev_stall = 1'b0;
    prev = '0;
    acc_q.delete();
    valid_cycles = 0; done_cnt = 0; done_at = -1; first_valid_at = -1;
    stall_changes = 0; timed_out = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      if (io_frame_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (line_if.io_line_valid) begin
        valid_cycles++;
        if (first_valid_at < 0) first_valid_at = c;
      end
      if (prev_stall && cur_seg() != prev) stall_changes++;
      rdy = rdy_pat[c];
      line_if.io_line_ready = rdy;
      word_if.io_word_valid = (c == inject_at);
      if (c == inject_at) word_if.io_word = 16'($urandom);
      if (line_if.io_line_valid && rdy) acc_q.push_back(cur_seg());
      prev_stall = line_if.io_line_valid && !rdy;
      prev = cur_seg();
      tick();
      if (done_at >= 0 && c >= done_at + 2) begin
        timed_out = 1'b0;
        break;
      end
    end
    word_if.io_word_valid = 1'b0;
    line_if.io_line_ready = 1'b0;
  endtask

  function automatic logic [15:0] rand_idx();
    int r;
    r = $urandom_range(0, 11);
    if (r < 8)  return 16'(r % 4);
    if (r < 10) return 16'(4 + r % 4);
    return 16'h0100 | 16'(r % 4);
  endfunction

  task automatic test_reset();
    io_aresetn = 1'b1;
    word_if.io_spi_cs = 1'b1; word_if.io_word_valid = 1'b0; word_if.io_word = '0;
    line_if.io_line_ready = 1'b0;
    #1 io_aresetn = 1'b0;
    #1;
    checks++; if (line_if.io_line_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", line_if.io_line_valid); end
    checks++; if (cur_seg() !== '0) begin errors++; $display("FAIL rst_coords got %h want 0", cur_seg()); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", io_busy); end
    checks++; if (io_frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", io_frame_done); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", io_err); end
    tick(); tick();
    io_aresetn = 1'b1;
    tick(); tick();
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", io_busy); end
  endtask

  task automatic test_square();
    set_square(); fill_ready(0); build_model(); drive_frame(1'b0); collect(-1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL sq_timeout got %b want 0", timed_out); end
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL sq_count got %0d want 4", acc_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL sq_line%0d got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (first_valid_at != 0) begin errors++; $display("FAIL sq_first_valid got %0d want 0", first_valid_at); end
    checks++; if (valid_cycles != 4) begin errors++; $display("FAIL sq_valid_cycles got %0d want 4", valid_cycles); end
    checks++; if (done_at != exp_done_at) begin errors++; $display("FAIL sq_done_at got %0d want %0d", done_at, exp_done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL sq_done_cnt got %0d want 1", done_cnt); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL sq_err got %b want 0", io_err); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL sq_busy_end got %b want 0", io_busy); end
  endtask

  task automatic test_stall();
    set_square(); fill_ready(1); build_model(); drive_frame(1'b0); collect(-1);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got %b want 0", timed_out); end
    checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_line%0d got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (stall_changes != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", stall_changes); end
    checks++; if (valid_cycles != exp_valid_cycles) begin errors++; $display("FAIL stall_valid_cycles got %0d want %0d", valid_cycles, exp_valid_cycles); end
    checks++; if (done_at != exp_done_at) begin errors++; $display("FAIL stall_done_at got %0d want %0d", done_at, exp_done_at); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL stall_err got %b want 0", io_err); end
  endtask

  task automatic test_bad_index();
    set_square(); ma[2] = 16'd1; mb[2] = 16'd5;
    fill_ready(0); build_model(); drive_frame(1'b0); collect(-1);
    checks++; if (acc_q.size() != 3) begin errors++; $display("FAIL bad_count got %0d want 3", acc_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL bad_line%0d got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (done_at != exp_done_at) begin errors++; $display("FAIL bad_done_at got %0d want %0d", done_at, exp_done_at); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bad_done_cnt got %0d want 1", done_cnt); end
    checks++; if (io_err !== exp_err) begin errors++; $display("FAIL bad_err got %b want %b", io_err, exp_err); end
  endtask

  task automatic test_abort();
    bit saw_valid;
    set_square();
    word_if.io_spi_cs = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) send_word(mv[k / 4][k % 4], 1'b0);
    checks++; if (io_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", io_busy); end
    word_if.io_spi_cs = 1'b1;
    tick();
    saw_valid = 1'b0;
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", io_busy); end
    checks++; if (io_err !== 1'b1) begin errors++; $display("FAIL abort_err got %b want 1", io_err); end
    repeat (6) begin
      if (line_if.io_line_valid) saw_valid = 1'b1;
      tick();
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", saw_valid); end
    fill_ready(0); build_model(); drive_frame(1'b0); collect(-1);
    checks++; if (acc_q.size() != 4) begin errors++; $display("FAIL abort_next_count got %0d want 4", acc_q.size()); end
    checks++; if (io_err !== 1'b0) begin errors++; $display("FAIL abort_next_err got %b want 0", io_err); end
  endtask

  task automatic test_overrun();
    set_square(); fill_ready(3); build_model(); drive_frame(1'b0); collect(1);
    checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL ovr_count got %0d want %0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovr_line%0d got %h want %h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (stall_changes != 0) begin errors++; $display("FAIL ovr_hold got %0d changes want 0", stall_changes); end
    checks++; if (io_err !== 1'b1) begin errors++; $display("FAIL ovr_err got %b want 1", io_err); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      for (int v = 0; v < 4; v++)
        for (int c = 0; c < 4; c++) mv[v][c] = 16'($urandom);
      for (int l = 0; l < 4; l++) begin
        ma[l] = rand_idx();
        mb[l] = rand_idx();
      end
      fill_ready(2); build_model(); drive_frame(1'b1); collect(-1);
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got %b want 0", f, timed_out); end
      checks++; if (acc_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", f, acc_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
        checks++; if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_line%0d got %h want %h", f, i, acc_q[i], exp_q[i]); end
      end
      checks++; if (done_at != exp_done_at) begin errors++; $display("FAIL rnd%0d_done_at got %0d want %0d", f, done_at, exp_done_at); end
      checks++; if (valid_cycles != exp_valid_cycles) begin errors++; $display("FAIL rnd%0d_valid_cycles got %0d want %0d", f, valid_cycles, exp_valid_cycles); end
      checks++; if (stall_changes != 0) begin errors++; $display("FAIL rnd%0d_hold got %0d want 0", f, stall_changes); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd%0d_done_cnt got %0d want 1", f, done_cnt); end
      checks++; if (io_err !== exp_err) begin errors++; $display("FAIL rnd%0d_err got %b want %b", f, io_err, exp_err); end
    end
  endtask

  task automatic test_reset_mid_draw();
    bit saw_valid;
    set_square(); fill_ready(0); build_model(); drive_frame(1'b0);
    checks++; if (line_if.io_line_valid !== 1'b1 || cur_seg() !== exp_q[0]) begin errors++; $display("FAIL mid_line0 got %b/%h want 1/%h", line_if.io_line_valid, cur_seg(), exp_q[0]); end
    line_if.io_line_ready = 1'b1;
    tick();
    line_if.io_line_ready = 1'b0;
    tick();
    checks++; if (line_if.io_line_valid !== 1'b1 || cur_seg() !== exp_q[1]) begin errors++; $display("FAIL mid_line1_stall got %b/%h want 1/%h", line_if.io_line_valid, cur_seg(), exp_q[1]); end
    io_aresetn = 1'b0;
    #1;
    checks++; if (line_if.io_line_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", line_if.io_line_valid); end
    checks++; if (cur_seg() !== '0) begin errors++; $display("FAIL mid_rst_coords got %h want 0", cur_seg()); end
    checks++; if (io_busy !== 1'b0 || io_err !== 1'b0 || io_frame_done !== 1'b0) begin errors++; $display("FAIL mid_rst_status got busy %b err %b done %b want 0 0 0", io_busy, io_err, io_frame_done); end
    tick(); tick();
    io_aresetn = 1'b1;
    line_if.io_line_ready = 1'b1;
    saw_valid = 1'b0;
    repeat (8) begin
      if (line_if.io_line_valid) saw_valid = 1'b1;
      tick();
    end
    checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL mid_after_valid got %b want 0", saw_valid); end
    checks++; if (io_busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy got %b want 0", io_busy); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_stall();
    test_bad_index();
    test_abort();
    test_overrun();
    test_random();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
